// File: rtl/sd_responder_pkg.sv
// Shared types and constants for the SD-card SPI-mode responder.
package sd_responder_pkg;

  typedef enum logic [2:0] {
    ST_HUNT, ST_CMD, ST_NCR, ST_RESP, ST_NAC, ST_TOKEN, ST_DATA, ST_CRC
  } state_t;

  localparam logic [5:0] CMD_GO_IDLE         = 6'd0;
  localparam logic [5:0] CMD_SEND_IF_COND    = 6'd8;
  localparam logic [5:0] CMD_READ_SINGLE     = 6'd17;
  localparam logic [5:0] CMD_SD_SEND_OP_COND = 6'd41;
  localparam logic [5:0] CMD_APP_CMD         = 6'd55;
  localparam logic [5:0] CMD_READ_OCR        = 6'd58;

  localparam logic [7:0] DATA_TOKEN  = 8'hFE;
  localparam logic [7:0] IDLE_BYTE   = 8'hFF;
  localparam int         BLOCK_BYTES = 512;

  function automatic logic [7:0] r1_byte(input logic idle, input logic illegal);
    return {5'b0, illegal, 1'b0, idle};
  endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 slave front end: input synchronizers, SCLK edge detect, bit counter
// and the receive/transmit byte shift registers.
module sd_spi_shifter
  import sd_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic [7:0] tx_byte,
  output logic       cs_sync,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       tx_load,
  output logic       miso
);

  logic [1:0] cs_ff, sclk_ff, mosi_ff;
  logic       sclk_d;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sh;
  logic [7:0] tx_sh;
  logic       load_pend;
  logic       sclk_rise, sclk_fall;

  assign cs_sync   = cs_ff[1];
  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[1] & sclk_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_ff     <= 2'b11;
      sclk_ff   <= 2'b00;
      mosi_ff   <= 2'b00;
      sclk_d    <= 1'b0;
      bit_cnt   <= '0;
      rx_sh     <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      tx_sh     <= IDLE_BYTE;
      tx_load   <= 1'b0;
      load_pend <= 1'b0;
      miso      <= 1'b1;
    end else begin
      cs_ff    <= {cs_ff[0], spi_cs};
      sclk_ff  <= {sclk_ff[0], spi_sclk};
      mosi_ff  <= {mosi_ff[0], spi_mosi};
      sclk_d   <= sclk_ff[1];
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      if (cs_ff[1]) begin
        bit_cnt   <= '0;
        load_pend <= 1'b0;
        tx_sh     <= IDLE_BYTE;
        miso      <= 1'b1;
      end else if (sclk_rise) begin
        rx_sh   <= {rx_sh[5:0], mosi_ff[1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_valid  <= 1'b1;
          rx_byte   <= {rx_sh, mosi_ff[1]};
          load_pend <= 1'b1;
        end
      end else if (sclk_fall) begin
        // the fall closing a byte loads the next one with its MSB already on the wire
        if (load_pend) begin
          tx_sh     <= tx_byte;
          miso      <= tx_byte[7];
          load_pend <= 1'b0;
          tx_load   <= 1'b1;
        end else begin
          tx_sh <= {tx_sh[6:0], 1'b1};
          miso  <= tx_sh[6];
        end
      end
    end
  end

endmodule

// File: rtl/sd_responder.sv
// SD-card SPI-mode responder: answers the init command subset and streams one block per CMD17.
// state  | meaning
// HUNT   | waiting for a 01xxxxxx command byte
// CMD    | collecting 4 argument bytes and the CRC byte
// NCR    | 0xFF filler before the response
// RESP   | sending R1 / R3 / R7 bytes
// NAC    | 0xFF filler before the data token
// TOKEN  | sending 0xFE
// DATA   | streaming block bytes from rd_data
// CRC    | two 0xFF CRC bytes
module sd_responder
  import sd_responder_pkg::*;
#(
  parameter int INIT_RETRIES = 1,
  parameter int NCR_BYTES    = 1,
  parameter int NAC_BYTES    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SPI_CS,
  input  logic        SPI_SCLK,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  output logic        rd_req,
  output logic [31:0] rd_lba,
  output logic [8:0]  rd_addr,
  input  logic [7:0]  rd_data
);

  localparam logic [9:0] NCR_LAST  = 10'(NCR_BYTES - 1);
  localparam logic [9:0] NAC_LAST  = 10'(NAC_BYTES - 1);
  localparam logic [9:0] DATA_LAST = 10'(BLOCK_BYTES - 1);

  state_t      state;
  logic        cs_sync, rx_valid, tx_load;
  logic [7:0]  rx_byte, tx_byte;
  logic [5:0]  cmd_idx;
  logic [31:0] arg;
  logic [9:0]  cnt;
  logic        idle, app, go_data;
  logic [7:0]  retry;
  logic [39:0] resp_q;
  logic [2:0]  resp_len;

  logic        acmd41, idle_n, go_n;
  logic [7:0]  retry_n, r1;
  logic [39:0] resp_n;
  logic [2:0]  len_n;

  sd_spi_shifter u_shifter (
    .clock    (clock),
    .reset    (reset),
    .spi_cs   (SPI_CS),
    .spi_sclk (SPI_SCLK),
    .spi_mosi (SPI_MOSI),
    .tx_byte  (tx_byte),
    .cs_sync  (cs_sync),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_load  (tx_load),
    .miso     (SPI_MISO)
  );

  // Response and flag updates for the command whose CRC byte is arriving.
  always_comb begin
    acmd41  = app && (cmd_idx == CMD_SD_SEND_OP_COND);
    idle_n  = idle;
    retry_n = retry;
    if (cmd_idx == CMD_GO_IDLE) begin
      idle_n  = 1'b1;
      retry_n = '0;
    end else if (acmd41) begin
      if (retry < 8'(INIT_RETRIES)) retry_n = retry + 8'd1;
      else                          idle_n  = 1'b0;
    end
    r1     = r1_byte(idle_n, 1'b0);
    resp_n = {r1, 32'hFFFF_FFFF};
    len_n  = 3'd1;
    go_n   = 1'b0;
    case (cmd_idx)
      CMD_GO_IDLE, CMD_APP_CMD: begin end
      CMD_SEND_IF_COND: begin
        resp_n = {r1, 24'h00_0001, arg[7:0]};
        len_n  = 3'd5;
      end
      CMD_READ_OCR: begin
        resp_n = {r1, 32'hC0FF_8000};
        len_n  = 3'd5;
      end
      CMD_READ_SINGLE:     go_n = !idle;
      CMD_SD_SEND_OP_COND: if (!acmd41) resp_n = {r1_byte(idle_n, 1'b1), 32'hFFFF_FFFF};
      default:             resp_n = {r1_byte(idle_n, 1'b1), 32'hFFFF_FFFF};
    endcase
  end

  // Each rx_valid closes a byte slot; tx_byte is what the next slot will carry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_HUNT;
      tx_byte  <= IDLE_BYTE;
      cmd_idx  <= '0;
      arg      <= '0;
      cnt      <= '0;
      idle     <= 1'b1;
      app      <= 1'b0;
      retry    <= '0;
      resp_q   <= '1;
      resp_len <= 3'd1;
      go_data  <= 1'b0;
      rd_req   <= 1'b0;
      rd_lba   <= '0;
      rd_addr  <= '0;
    end else begin
      rd_req <= 1'b0;
      if (cs_sync) begin
        state   <= ST_HUNT;
        tx_byte <= IDLE_BYTE;
      end else begin
        if (tx_load && state == ST_DATA) rd_addr <= rd_addr + 9'd1;
        if (rx_valid) begin
          tx_byte <= IDLE_BYTE;
          case (state)
            ST_HUNT:
              if (rx_byte[7:6] == 2'b01) begin
                state   <= ST_CMD;
                cmd_idx <= rx_byte[5:0];
                cnt     <= '0;
              end
            ST_CMD:
              if (cnt == 10'd4) begin
                idle     <= idle_n;
                retry    <= retry_n;
                app      <= (cmd_idx == CMD_APP_CMD);
                resp_q   <= resp_n;
                resp_len <= len_n;
                go_data  <= go_n;
                if (go_n) begin
                  rd_req  <= 1'b1;
                  rd_lba  <= arg;
                  rd_addr <= '0;
                end
                state <= ST_NCR;
                cnt   <= '0;
              end else begin
                arg <= {arg[23:0], rx_byte};
                cnt <= cnt + 10'd1;
              end
            ST_NCR:
              if (cnt == NCR_LAST) begin
                state   <= ST_RESP;
                cnt     <= 10'd1;
                tx_byte <= resp_q[39:32];
                resp_q  <= {resp_q[31:0], IDLE_BYTE};
              end else cnt <= cnt + 10'd1;
            ST_RESP:
              if (cnt == {7'd0, resp_len}) begin
                state <= go_data ? ST_NAC : ST_HUNT;
                cnt   <= '0;
              end else begin
                tx_byte <= resp_q[39:32];
                resp_q  <= {resp_q[31:0], IDLE_BYTE};
                cnt     <= cnt + 10'd1;
              end
            ST_NAC:
              if (cnt == NAC_LAST) begin
                state   <= ST_TOKEN;
                tx_byte <= DATA_TOKEN;
              end else cnt <= cnt + 10'd1;
            ST_TOKEN: begin
              state   <= ST_DATA;
              tx_byte <= rd_data;
              cnt     <= '0;
            end
            ST_DATA:
              if (cnt == DATA_LAST) begin
                state <= ST_CRC;
                cnt   <= '0;
              end else begin
                tx_byte <= rd_data;
                cnt     <= cnt + 10'd1;
              end
            ST_CRC:
              if (cnt == 10'd1) state <= ST_HUNT;
              else              cnt   <= cnt + 10'd1;
          endcase
        end
      end
    end
  end

endmodule
